// File: rtl/riscv_config_pkg.sv
// Build-time configuration of the dual-issue core's register file.
package riscv_config_pkg;

  localparam int RF_NUM_RD_PORTS = 4;
  localparam int RF_NUM_WR_PORTS = 2;
  localparam bit RF_BYPASS_EN    = 1'b1;

endpackage

// File: rtl/riscv_core_pkg.sv
// Core-wide architectural types shared by the integer pipeline.
package riscv_core_pkg;

  localparam int XLEN          = 32;
  localparam int NUM_ARCH_REGS = 32;
  localparam int REG_ADDR_W    = $clog2(NUM_ARCH_REGS);

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits (alloc at issue, clear at writeback) and the
// registered same-address write-conflict flag.
module rf_scoreboard #(
  parameter int REG_COUNT      = 32,
  parameter int REG_ADDR_WIDTH = $clog2(REG_COUNT),
  parameter int NUM_WR         = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_WR-1:0]                    wr_en_i,
  input  logic [NUM_WR-1:0][REG_ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [NUM_WR-1:0]                    alloc_en_i,
  input  logic [NUM_WR-1:0][REG_ADDR_WIDTH-1:0] alloc_addr_i,
  output logic [REG_COUNT-1:0]                 busy_vec_o,
  output logic                                 wr_conflict_o
);

  logic [REG_COUNT-1:0] set_vec, clr_vec, busy_d, busy_q;
  logic                 conflict_d, conflict_q;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    set_vec    = '0;
    clr_vec    = '0;
    conflict_d = 1'b0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (alloc_en_i[w] && alloc_addr_i[w] != '0) set_vec[alloc_addr_i[w]] = 1'b1;
      if (wr_en_i[w] && wr_addr_i[w] != '0)       clr_vec[wr_addr_i[w]]    = 1'b1;
      for (int v = w + 1; v < NUM_WR; v++) begin
        if (wr_en_i[w] && wr_en_i[v] && wr_addr_i[w] == wr_addr_i[v] && wr_addr_i[w] != '0)
          conflict_d = 1'b1;
      end
    end
    // A younger alloc supersedes a same-cycle writeback, so set wins over clear.
    busy_d    = set_vec | (busy_q & ~clr_vec);
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign busy_vec_o    = busy_q;
  assign wr_conflict_o = conflict_q;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!rst_i) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en_i[w] && wr_addr_i[w] != '0)
          assert (busy_q[wr_addr_i[w]])
            else $warning("rf_scoreboard: write port %0d targets non-busy x%0d", w, wr_addr_i[w]);
        for (int v = w + 1; v < NUM_WR; v++) begin
          assert (!(alloc_en_i[w] && alloc_en_i[v] &&
                    alloc_addr_i[w] == alloc_addr_i[v] && alloc_addr_i[w] != '0))
            else $error("rf_scoreboard: issue violation, alloc ports %0d and %0d both target x%0d",
                        w, v, alloc_addr_i[w]);
        end
      end
    end
  end
`endif

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file: async reads with optional write bypass,
// prioritised synchronous writes, and a busy-bit scoreboard.
module reg_file_mp
  import riscv_core_pkg::*;
  import riscv_config_pkg::*;
#(
  parameter int DATA_WIDTH     = $bits(word_t),
  parameter int REG_COUNT      = 2 ** $bits(reg_addr_t),
  parameter int REG_ADDR_WIDTH = $clog2(REG_COUNT),
  parameter int NUM_RD         = RF_NUM_RD_PORTS,
  parameter int NUM_WR         = RF_NUM_WR_PORTS,
  parameter bit BYPASS_EN      = RF_BYPASS_EN
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_WR-1:0]                     wr_en_i,
  input  logic [NUM_WR-1:0][REG_ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]     wr_data_i,
  input  logic [NUM_RD-1:0][REG_ADDR_WIDTH-1:0] rd_addr_i,
  output logic [NUM_RD-1:0][DATA_WIDTH-1:0]     rd_data_o,
  output logic [NUM_RD-1:0]                     rd_busy_o,
  input  logic [NUM_WR-1:0]                     alloc_en_i,
  input  logic [NUM_WR-1:0][REG_ADDR_WIDTH-1:0] alloc_addr_i,
  output logic                                  wr_conflict_o,
  output logic [REG_COUNT-1:0]                  busy_vec_o
);

  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [NUM_RD-1:0]     rd_hit;

  // NOTE: this array is reset explicitly because reads must return zero during and after reset;
  // a plain storage array would normally be left unreset so it can map onto RAM.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < REG_COUNT; r++) regs_q[r] <= '0;
    end else begin
      // NOTE: non-blocking updates in port order; the last one scheduled (highest port) wins.
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en_i[w] && wr_addr_i[w] != '0) regs_q[wr_addr_i[w]] <= wr_data_i[w];
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    rd_hit    = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_data_o[p] = regs_q[rd_addr_i[p]];
      if (BYPASS_EN) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_en_i[w] && wr_addr_i[w] == rd_addr_i[p]) begin
            rd_data_o[p] = wr_data_i[w];
            rd_hit[p]    = 1'b1;
          end
        end
      end
      // x0 and an in-progress reset both force zero, overriding any bypass.
      if (rd_addr_i[p] == '0 || rst_i) begin
        rd_data_o[p] = '0;
        rd_hit[p]    = 1'b0;
      end
      rd_busy_o[p] = busy_vec_o[rd_addr_i[p]] & ~rd_hit[p];
    end
  end

  rf_scoreboard #(
    .REG_COUNT      (REG_COUNT),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .NUM_WR         (NUM_WR)
  ) u_scoreboard (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .wr_en_i       (wr_en_i),
    .wr_addr_i     (wr_addr_i),
    .alloc_en_i    (alloc_en_i),
    .alloc_addr_i  (alloc_addr_i),
    .busy_vec_o    (busy_vec_o),
    .wr_conflict_o (wr_conflict_o)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a bypass and a no-bypass instance share stimulus;
// expectations are queued by the stimulus and compared by a negedge monitor.
module tb_reg_file_mp;

  localparam logic BYP = 1'b0;
  localparam logic NOB = 1'b1;

  typedef enum logic [2:0] {K_RD_DATA, K_RD_BUSY, K_BUSY_BIT, K_BUSY_VEC, K_CONFLICT} kind_e;
  typedef struct packed {
    kind_e       kind;
    logic        dut;
    logic [4:0]  idx;
    logic [31:0] val;
  } exp_t;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [1:0]       wr_en;
  logic [1:0][4:0]  wr_addr;
  logic [1:0][31:0] wr_data;
  logic [3:0][4:0]  rd_addr;
  logic [1:0]       alloc_en;
  logic [1:0][4:0]  alloc_addr;

  logic [3:0][31:0] rd_data_b, rd_data_n;
  logic [3:0]       rd_busy_b, rd_busy_n;
  logic             conflict_b, conflict_n;
  logic [31:0]      busy_vec_b, busy_vec_n;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  always #5 clk_i = ~clk_i;

  reg_file_mp #(.BYPASS_EN(1'b1)) u_dut_byp (
    .clk_i(clk_i), .rst_i(rst_i),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data_b), .rd_busy_o(rd_busy_b),
    .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr),
    .wr_conflict_o(conflict_b), .busy_vec_o(busy_vec_b)
  );

  reg_file_mp #(.BYPASS_EN(1'b0)) u_dut_nob (
    .clk_i(clk_i), .rst_i(rst_i),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data_n), .rd_busy_o(rd_busy_n),
    .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr),
    .wr_conflict_o(conflict_n), .busy_vec_o(busy_vec_n)
  );

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    wr_en      = '0;
    wr_addr    = '0;
    wr_data    = '0;
    alloc_en   = '0;
    alloc_addr = '0;
  endtask

  task automatic wr(input int port, input int addr, input logic [31:0] data);
    wr_en[port]   = 1'b1;
    wr_addr[port] = addr[4:0];
    wr_data[port] = data;
  endtask

  task automatic alloc(input int port, input int addr);
    alloc_en[port]   = 1'b1;
    alloc_addr[port] = addr[4:0];
  endtask

  task automatic rd(input int port, input int addr);
    rd_addr[port] = addr[4:0];
  endtask

  task automatic chk(input kind_e k, input logic d, input int idx, input logic [31:0] v,
                     input string nm);
    exp_t e;
    e.kind = k;
    e.dut  = d;
    e.idx  = idx[4:0];
    e.val  = v;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: outputs are combinational or registered, so every queued expectation
  // for the current cycle is settled by the falling edge.
  always @(negedge clk_i) begin : monitor
    exp_t        e;
    string       nm;
    logic [31:0] act;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = '0;
      case (e.kind)
        K_RD_DATA:  act = e.dut ? rd_data_n[e.idx[1:0]] : rd_data_b[e.idx[1:0]];
        K_RD_BUSY:  act = {31'b0, e.dut ? rd_busy_n[e.idx[1:0]] : rd_busy_b[e.idx[1:0]]};
        K_BUSY_BIT: act = {31'b0, e.dut ? busy_vec_n[e.idx] : busy_vec_b[e.idx]};
        K_BUSY_VEC: act = e.dut ? busy_vec_n : busy_vec_b;
        K_CONFLICT: act = {31'b0, e.dut ? conflict_n : conflict_b};
        default:    act = 'x;
      endcase
      n_checks++;
      if (act !== e.val) begin
        n_errors++;
        $display("FAIL %s (%s): got 0x%08h, expected 0x%08h", nm, e.dut ? "nobyp" : "byp", act, e.val);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_i   = 1'b1;
    rd_addr = '0;
    idle();

    // Reset state
    cyc();
    rd(0, 5);
    chk(K_RD_DATA,  BYP, 0, 32'h0, "reset_rd_data");
    chk(K_RD_BUSY,  BYP, 0, 32'h0, "reset_rd_busy");
    chk(K_BUSY_VEC, BYP, 0, 32'h0, "reset_busy_vec");
    chk(K_CONFLICT, BYP, 0, 32'h0, "reset_conflict");
    cyc();
    rst_i = 1'b0;

    // 1. Write x5, then asynchronous reset mid-cycle
    cyc(); idle(); alloc(0, 5); alloc(1, 6); rd(0, 5);
    chk(K_BUSY_VEC, BYP, 0, 32'h0, "t1_alloc_not_yet_visible");
    cyc(); idle(); wr(0, 5, 32'hDEAD_BEEF); rd(0, 5);
    chk(K_RD_DATA,  BYP, 0, 32'hDEAD_BEEF, "t1_bypass_data");
    chk(K_RD_DATA,  NOB, 0, 32'h0,         "t1_nobypass_old");
    chk(K_RD_BUSY,  BYP, 0, 32'h0,         "t1_busy_masked_by_write");
    chk(K_RD_BUSY,  NOB, 0, 32'h1,         "t1_busy_unmasked");
    chk(K_BUSY_VEC, BYP, 0, 32'h0000_0060, "t1_busy_vec_alloc");
    cyc(); idle(); rd(0, 5);
    chk(K_RD_DATA,  BYP, 0, 32'hDEAD_BEEF, "t1_stored");
    chk(K_RD_DATA,  NOB, 0, 32'hDEAD_BEEF, "t1_stored");
    chk(K_BUSY_VEC, BYP, 0, 32'h0000_0040, "t1_busy_vec_after_wb");
    cyc(); idle();
    #1 rst_i = 1'b1;
    chk(K_RD_DATA,  BYP, 0, 32'h0, "t1_async_rst_data");
    chk(K_RD_DATA,  NOB, 0, 32'h0, "t1_async_rst_data");
    chk(K_BUSY_VEC, BYP, 0, 32'h0, "t1_async_rst_busy_vec");
    chk(K_BUSY_VEC, NOB, 0, 32'h0, "t1_async_rst_busy_vec");
    #5 rst_i = 1'b0;
    cyc(); idle(); rd(0, 5);
    chk(K_RD_DATA,  BYP, 0, 32'h0, "t1_after_rst_data");
    chk(K_BUSY_VEC, BYP, 0, 32'h0, "t1_after_rst_busy_vec");

    // 2. Same-cycle write/read of x5
    cyc(); idle(); alloc(0, 5); rd(0, 5);
    cyc(); idle(); wr(0, 5, 32'h1234_5678); rd(0, 5); rd(1, 5);
    chk(K_RD_DATA, BYP, 0, 32'h1234_5678, "t2_bypass_p0");
    chk(K_RD_DATA, BYP, 1, 32'h1234_5678, "t2_bypass_p1");
    chk(K_RD_DATA, NOB, 0, 32'h0,         "t2_nobypass_old");
    cyc(); idle(); rd(0, 5);
    chk(K_RD_DATA,  BYP, 0, 32'h1234_5678, "t2_next_cycle");
    chk(K_RD_DATA,  NOB, 0, 32'h1234_5678, "t2_next_cycle");
    chk(K_BUSY_VEC, BYP, 0, 32'h0,         "t2_busy_vec_cleared");

    // 3. Two write ports hit x7: port 1 wins, conflict pulses once
    cyc(); idle(); alloc(0, 7); rd(0, 7);
    cyc(); idle(); wr(0, 7, 32'hAAAA_0000); wr(1, 7, 32'h5555_0000); rd(0, 7); rd(2, 7);
    chk(K_RD_DATA,  BYP, 0, 32'h5555_0000, "t3_bypass_priority");
    chk(K_RD_DATA,  BYP, 2, 32'h5555_0000, "t3_bypass_priority_p2");
    chk(K_RD_DATA,  NOB, 0, 32'h0,         "t3_nobypass_old");
    chk(K_CONFLICT, BYP, 0, 32'h0,         "t3_conflict_not_yet");
    cyc(); idle(); rd(0, 7);
    chk(K_RD_DATA,  BYP, 0, 32'h5555_0000, "t3_stored_priority");
    chk(K_RD_DATA,  NOB, 0, 32'h5555_0000, "t3_stored_priority");
    chk(K_CONFLICT, BYP, 0, 32'h1,         "t3_conflict_pulse");
    chk(K_CONFLICT, NOB, 0, 32'h1,         "t3_conflict_pulse");
    cyc(); idle(); rd(0, 7);
    chk(K_CONFLICT, BYP, 0, 32'h0,         "t3_conflict_one_cycle");

    // 4. x0 writes/alloc are ignored and never conflict
    cyc(); idle(); wr(0, 0, 32'hFFFF_FFFF); wr(1, 0, 32'h1234_5678); alloc(0, 0);
    rd(0, 0); rd(3, 0);
    chk(K_RD_DATA, BYP, 0, 32'h0, "t4_x0_bypass_zero");
    chk(K_RD_DATA, BYP, 3, 32'h0, "t4_x0_bypass_zero_p3");
    chk(K_RD_DATA, NOB, 0, 32'h0, "t4_x0_zero");
    chk(K_RD_BUSY, BYP, 0, 32'h0, "t4_x0_rd_busy");
    cyc(); idle(); rd(0, 0);
    chk(K_RD_DATA,  BYP, 0, 32'h0, "t4_x0_stored_zero");
    chk(K_BUSY_BIT, BYP, 0, 32'h0, "t4_x0_busy_bit");
    chk(K_BUSY_VEC, BYP, 0, 32'h0, "t4_busy_vec");
    chk(K_CONFLICT, BYP, 0, 32'h0, "t4_x0_no_conflict");
    chk(K_CONFLICT, NOB, 0, 32'h0, "t4_x0_no_conflict");

    // 5. Alloc x3 then writeback
    cyc(); idle(); alloc(1, 3); rd(0, 3); rd(3, 3);
    chk(K_RD_BUSY,  BYP, 0, 32'h0, "t5_alloc_not_visible");
    chk(K_BUSY_BIT, BYP, 3, 32'h0, "t5_busy_bit_not_yet");
    cyc(); idle(); rd(0, 3);
    chk(K_RD_BUSY,  BYP, 0, 32'h1, "t5_rd_busy_set");
    chk(K_RD_BUSY,  NOB, 0, 32'h1, "t5_rd_busy_set");
    chk(K_BUSY_BIT, BYP, 3, 32'h1, "t5_busy_bit_set");
    cyc(); idle(); wr(1, 3, 32'h0000_0042); rd(0, 3); rd(3, 3);
    chk(K_RD_DATA,  BYP, 0, 32'h0000_0042, "t5_bypass_data");
    chk(K_RD_DATA,  BYP, 3, 32'h0000_0042, "t5_bypass_data_p3");
    chk(K_RD_BUSY,  BYP, 0, 32'h0,         "t5_rd_busy_bypassed");
    chk(K_RD_DATA,  NOB, 0, 32'h0,         "t5_nobypass_old");
    chk(K_RD_BUSY,  NOB, 0, 32'h1,         "t5_nobypass_busy");
    chk(K_BUSY_BIT, BYP, 3, 32'h1,         "t5_busy_bit_still_set");
    cyc(); idle(); rd(0, 3);
    chk(K_BUSY_BIT, BYP, 3, 32'h0,         "t5_busy_bit_cleared");
    chk(K_BUSY_BIT, NOB, 3, 32'h0,         "t5_busy_bit_cleared");
    chk(K_RD_BUSY,  BYP, 0, 32'h0,         "t5_rd_busy_cleared");
    chk(K_RD_DATA,  NOB, 0, 32'h0000_0042, "t5_stored");

    // 6. Alloc and write x9 in the same cycle: data lands, x9 stays busy
    cyc(); idle(); alloc(0, 9); rd(2, 9);
    cyc(); idle(); alloc(0, 9); wr(0, 9, 32'h0BAD_F00D); rd(2, 9);
    chk(K_RD_DATA, BYP, 2, 32'h0BAD_F00D, "t6_bypass_data");
    chk(K_RD_BUSY, BYP, 2, 32'h0,         "t6_rd_busy_bypassed");
    chk(K_RD_DATA, NOB, 2, 32'h0,         "t6_nobypass_old");
    chk(K_RD_BUSY, NOB, 2, 32'h1,         "t6_nobypass_busy");
    cyc(); idle(); rd(2, 9);
    chk(K_RD_DATA,  BYP, 2, 32'h0BAD_F00D, "t6_stored");
    chk(K_RD_DATA,  NOB, 2, 32'h0BAD_F00D, "t6_stored");
    chk(K_BUSY_BIT, BYP, 9, 32'h1,         "t6_busy_bit_stays");
    chk(K_RD_BUSY,  BYP, 2, 32'h1,         "t6_rd_busy_stays");
    chk(K_BUSY_VEC, NOB, 0, 32'h0000_0200, "t6_busy_vec_final");

    // Drain the scoreboard, bounded
    cyc(); idle();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk_i);
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
